prio_enc_arb: RTL



---
 rtl/prio_enc_pkg.sv | 14 +
 rtl/prio_enc_comb.sv | 23 ++
 rtl/prio_enc_arb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the registered priority-encoder arbiter.
package prio_enc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Width of a binary index able to address n requesters.
    function automatic int enc_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational N-to-W encoder: index of the highest set bit plus an any-set flag.
module prio_enc_comb #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan, so the last hit (highest index) wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/prio_enc_arb.sv
// Registered priority-encoder arbiter with valid/ack handshake, MSB highest by default.
// Define PRIO_ENC_ROUND_ROBIN_EN to rotate priority so the last-served requester is lowest.
module prio_enc_arb
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = enc_width(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         z
);

    state_t         state_q, state_d;
    logic [W-1:0]   code_q, code_d;
    logic           valid_q, valid_d;
    logic           z_q, z_d;

    logic [N-1:0]   enc_in;
    logic [W-1:0]   enc_idx;
    logic           enc_any;
    logic [W-1:0]   winner;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]   search_ptr;
    logic [W:0]     unrot_sum;

    // An ack in GRANT retires code_q, so that index becomes the pointer the new search uses.
    assign search_ptr = (state_q == GRANT) ? code_q : ptr_q;

    for (genvar j = 0; j < N; j++) begin : g_rot
        logic [W:0]   rot_sum;
        logic [W-1:0] rot_idx;
        assign rot_sum    = {1'b0, search_ptr} + (W+1)'(j);
        assign rot_idx    = (rot_sum >= (W+1)'(N)) ? W'(rot_sum - (W+1)'(N)) : W'(rot_sum);
        assign enc_in[j]  = req[rot_idx];
    end

    assign unrot_sum = {1'b0, enc_idx} + {1'b0, search_ptr};
    assign winner    = (unrot_sum >= (W+1)'(N)) ? W'(unrot_sum - (W+1)'(N)) : W'(unrot_sum);

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == GRANT && ack) begin
            ptr_d = code_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign enc_in = req;
    assign winner = enc_idx;
`endif

    prio_enc_comb #(
        .N (N),
        .W (W)
    ) u_enc (
        .req (enc_in),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        z_d     = ~|req;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    code_d  = winner;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Grant is sticky; only ack releases it, re-arbitrating on the live req.
                if (ack) begin
                    if (enc_any) begin
                        code_d = winner;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            z_q     <= z_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign z     = z_q;

endmodule
